// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS read scheduler.
//   qid_t    : 2-bit queue identifier
//   weight_t : 6-bit unsigned weight
//   state_t  : scheduler FSM states
//   WT_Q0..WT_Q3 : occupancy -> weight tables (index 0..QDEPTH)
//   W_OVERRIDE   : weight forced when the override pattern occurs
//   base_weight(): table lookup for one queue at a clamped occupancy
package qos_pkg;

    localparam int NUM_Q  = 4;
    localparam int QDEPTH = 6;

    typedef logic [1:0] qid_t;
    typedef logic [5:0] weight_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Low occupancy favours Q0 (low-latency), high occupancy favours Q3.
    localparam weight_t WT_Q0 [0:QDEPTH] = '{6'd0, 6'd9, 6'd13, 6'd15, 6'd16, 6'd17, 6'd19};
    localparam weight_t WT_Q1 [0:QDEPTH] = '{6'd0, 6'd6, 6'd8,  6'd12, 6'd14, 6'd18, 6'd21};
    localparam weight_t WT_Q2 [0:QDEPTH] = '{6'd0, 6'd3, 6'd5,  6'd7,  6'd11, 6'd19, 6'd23};
    localparam weight_t WT_Q3 [0:QDEPTH] = '{6'd0, 6'd1, 6'd2,  6'd4,  6'd10, 6'd22, 6'd24};

    localparam weight_t W_OVERRIDE = 6'd20;

    // occ must already be clamped to 0..QDEPTH.
    function automatic weight_t base_weight(input qid_t q, input logic [2:0] occ);
        weight_t w;
        case (q)
            2'd0:    w = WT_Q0[occ];
            2'd1:    w = WT_Q1[occ];
            2'd2:    w = WT_Q2[occ];
            default: w = WT_Q3[occ];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/qos_read_scheduler_if.sv
// Bus between the QoS read scheduler and its neighbours.
//   master : queue storage / readout side (drives read_req, occ, head_data)
//   slave  : the scheduler (drives pop, readd, strobes and statistics)
interface qos_read_scheduler_if
    import qos_pkg::*;
#(
    parameter int OCC_W = 3,
    parameter int CNT_W = 10
);
    logic                     read_req;
    logic [NUM_Q*OCC_W-1:0]   occ;
    logic [2*NUM_Q-1:0]       head_data;
    logic [NUM_Q-1:0]         pop;
    logic [3:0]               readd;
    logic                     read_valid;
    logic                     read_empty;
    logic [CNT_W-1:0]         ct_received;
    logic [CNT_W-1:0]         ct_overrun;

    modport master (
        output read_req, occ, head_data,
        input  pop, readd, read_valid, read_empty, ct_received, ct_overrun
    );

    modport slave (
        input  read_req, occ, head_data,
        output pop, readd, read_valid, read_empty, ct_received, ct_overrun
    );
endinterface

// File: rtl/qos_weight_arbiter.sv
// Combinational weight arbiter.
//   occ_i          : snapshot occupancies, Qi at [i*OCC_W +: OCC_W]
//   winner_o       : queue with the greatest weight (ties -> higher index)
//   any_nonempty_o : at least one queue has non-zero weight
module qos_weight_arbiter
    import qos_pkg::*;
#(
    parameter int OCC_W = 3
) (
    input  logic [NUM_Q*OCC_W-1:0] occ_i,
    output qid_t                   winner_o,
    output logic                   any_nonempty_o
);

    logic [2:0] occ_c  [NUM_Q];
    weight_t    base_w [NUM_Q];
    weight_t    w      [NUM_Q];
    weight_t    best_w;

    // An occupancy above the queue depth is treated as a full queue.
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_lookup
        assign occ_c[gi] = (occ_i[gi*OCC_W +: OCC_W] > OCC_W'(QDEPTH))
                         ? 3'(QDEPTH) : 3'(occ_i[gi*OCC_W +: OCC_W]);
        assign base_w[gi] = base_weight(qid_t'(gi), occ_c[gi]);
    end

    // When Q0 is full and Q2 nearly full, one of them is pinned at the
    // override weight depending on how loaded Q1 is.
    always_comb begin
        w = base_w;
        if (occ_c[0] == 3'd6 && occ_c[2] == 3'd5) begin
            if (occ_c[1] < 3'd5) begin
                w[0] = W_OVERRIDE;
            end else begin
                w[2] = W_OVERRIDE;
            end
        end
    end

    // Ascending scan with >= lets a later (higher) index win a tie.
    always_comb begin
        best_w         = '0;
        winner_o       = '0;
        any_nonempty_o = 1'b0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (w[i] != '0 && w[i] >= best_w) begin
                best_w         = w[i];
                winner_o       = qid_t'(i);
                any_nonempty_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qos_read_scheduler.sv
// QoS dequeue scheduler: on a read request it snapshots queue occupancies,
// picks a winner through the weight arbiter and issues a one-hot pop.
//   clk, reset   : clock, synchronous active-high reset
//   rd_if.slave  : read_req/occ/head_data in; pop/readd/read_valid/
//                  read_empty/ct_received/ct_overrun out
// Latency: read_req in cycle k -> pop/read_valid/readd in cycle k+3,
// next request accepted in cycle k+4. One request arriving while busy is
// remembered; further ones are counted as overruns.
module qos_read_scheduler
    import qos_pkg::*;
#(
    parameter int OCC_W = 3,
    parameter int CNT_W = 10
) (
    input  logic           clk,
    input  logic           reset,
    qos_read_scheduler_if.slave rd_if
);

    state_t                  state_q,     state_d;
    logic                    pending_q,   pending_d;
    logic [NUM_Q*OCC_W-1:0]  occ_snap_q,  occ_snap_d;
    logic [2*NUM_Q-1:0]      head_snap_q, head_snap_d;
    qid_t                    winner_q,    winner_d;
    logic                    any_q,       any_d;
    logic [NUM_Q-1:0]        pop_q,       pop_d;
    logic [3:0]              readd_q,     readd_d;
    logic                    valid_q,     valid_d;
    logic                    empty_q,     empty_d;
    logic [CNT_W-1:0]        ct_rx_q,     ct_rx_d;
    logic [CNT_W-1:0]        ct_ovr_q,    ct_ovr_d;

    qid_t                    arb_winner;
    logic                    arb_any;
    logic [1:0]              head_sel;

    qos_weight_arbiter #(.OCC_W(OCC_W)) u_arb (
        .occ_i          (occ_snap_q),
        .winner_o       (arb_winner),
        .any_nonempty_o (arb_any)
    );

    assign head_sel = head_snap_q[{winner_q, 1'b0} +: 2];

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        occ_snap_d  = occ_snap_q;
        head_snap_d = head_snap_q;
        winner_d    = winner_q;
        any_d       = any_q;
        pop_d       = pop_q;
        readd_d     = readd_q;
        valid_d     = valid_q;
        empty_d     = empty_q;
        ct_rx_d     = ct_rx_q;
        ct_ovr_d    = ct_ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_if.read_req || pending_q) begin
                    occ_snap_d  = rd_if.occ;
                    head_snap_d = rd_if.head_data;
                    pending_d   = 1'b0;
                    state_d     = ST_EVAL;
                end
            end
            ST_EVAL: begin
                winner_d = arb_winner;
                any_d    = arb_any;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                valid_d = 1'b1;
                if (any_q) begin
                    pop_d   = NUM_Q'(1) << winner_q;
                    readd_d = {winner_q, head_sel};
                    empty_d = 1'b0;
                end else begin
                    pop_d   = '0;
                    readd_d = 4'b0000;
                    empty_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            default: begin // ST_WAIT: strobes are visible this cycle only
                pop_d   = '0;
                valid_d = 1'b0;
                empty_d = 1'b0;
                if (any_q) begin
                    ct_rx_d = ct_rx_q + CNT_W'(1);
                end
                state_d = ST_IDLE;
            end
        endcase

        // A single request can wait while busy; anything beyond it is lost.
        if (state_q != ST_IDLE && rd_if.read_req) begin
            if (pending_q) begin
                ct_ovr_d = ct_ovr_q + CNT_W'(1);
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            occ_snap_q  <= '0;
            head_snap_q <= '0;
            winner_q    <= '0;
            any_q       <= 1'b0;
            pop_q       <= '0;
            readd_q     <= '0;
            valid_q     <= 1'b0;
            empty_q     <= 1'b0;
            ct_rx_q     <= '0;
            ct_ovr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            occ_snap_q  <= occ_snap_d;
            head_snap_q <= head_snap_d;
            winner_q    <= winner_d;
            any_q       <= any_d;
            pop_q       <= pop_d;
            readd_q     <= readd_d;
            valid_q     <= valid_d;
            empty_q     <= empty_d;
            ct_rx_q     <= ct_rx_d;
            ct_ovr_q    <= ct_ovr_d;
        end
    end

    assign rd_if.pop         = pop_q;
    assign rd_if.readd       = readd_q;
    assign rd_if.read_valid  = valid_q;
    assign rd_if.read_empty  = empty_q;
    assign rd_if.ct_received = ct_rx_q;
    assign rd_if.ct_overrun  = ct_ovr_q;

endmodule

// File: tb/tb_qos_read_scheduler.sv
// Testbench for qos_read_scheduler: directed requests, a cycle-level
// request/response model checked every cycle, and literal spot checks.
module tb_qos_read_scheduler;

    logic clk;
    logic reset;

    qos_read_scheduler_if #(.OCC_W(3), .CNT_W(10)) bus ();

    qos_read_scheduler #(.OCC_W(3), .CNT_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .rd_if (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Weight tables written out from the rules.
    int wt [4][7] = '{
        '{0, 9, 13, 15, 16, 17, 19},
        '{0, 6,  8, 12, 14, 18, 21},
        '{0, 3,  5,  7, 11, 19, 23},
        '{0, 1,  2,  4, 10, 22, 24}
    };

    // Reference pick: largest weight, highest index among equals, none if all zero.
    function automatic void model_pick(input logic [11:0] occ, input logic [7:0] head,
                                       output logic [3:0] pop, output logic [3:0] readd,
                                       output logic empty);
        int o [4];
        int w [4];
        int maxw;
        int win;
        for (int i = 0; i < 4; i++) begin
            o[i] = int'(occ[i*3 +: 3]);
            if (o[i] > 6) o[i] = 6;
            w[i] = wt[i][o[i]];
        end
        if (o[0] == 6 && o[2] == 5) begin
            if (o[1] < 5) w[0] = 20;
            else          w[2] = 20;
        end
        maxw = 0;
        for (int i = 0; i < 4; i++) if (w[i] > maxw) maxw = w[i];
        win = 0;
        for (int i = 0; i < 4; i++) if (w[i] == maxw) win = i;
        if (maxw == 0) begin
            pop = 4'b0000; readd = 4'b0000; empty = 1'b1;
        end else begin
            pop   = 4'(1 << win);
            readd = {2'(win), head[2*win +: 2]};
            empty = 1'b0;
        end
    endfunction

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Cycle-level model: a request accepted in cycle n answers in n+3,
    // the scheduler is free again at n+4.
    initial begin
        int          mcyc;
        int          free_cyc;
        logic        m_pending;
        logic        resp_valid;
        int          resp_cyc;
        logic [3:0]  resp_pop, resp_readd, last_readd;
        logic        resp_empty;
        logic [31:0] m_rx, m_ovr;
        logic [3:0]  e_pop;
        logic        e_valid, e_empty;
        mcyc = 0; free_cyc = 0; m_pending = 0; resp_valid = 0; resp_cyc = 0;
        resp_pop = 0; resp_readd = 0; resp_empty = 0; last_readd = 0;
        m_rx = 0; m_ovr = 0;
        forever begin
            @(negedge clk);
            e_pop = 4'b0; e_valid = 1'b0; e_empty = 1'b0;
            if (resp_valid && resp_cyc == mcyc) begin
                e_pop = resp_pop; e_valid = 1'b1; e_empty = resp_empty;
                last_readd = resp_readd;
            end
            chk("m_pop",   32'(bus.pop),         32'(e_pop));
            chk("m_valid", 32'(bus.read_valid),  32'(e_valid));
            chk("m_empty", 32'(bus.read_empty),  32'(e_empty));
            chk("m_readd", 32'(bus.readd),       32'(last_readd));
            chk("m_rx",    32'(bus.ct_received), m_rx);
            chk("m_ovr",   32'(bus.ct_overrun),  m_ovr);
            if (resp_valid && resp_cyc == mcyc) begin
                if (!resp_empty) m_rx = (m_rx + 1) % 1024;
                resp_valid = 1'b0;
            end
            if (reset) begin
                m_pending = 0; resp_valid = 0; last_readd = 0;
                m_rx = 0; m_ovr = 0; free_cyc = mcyc + 1;
            end else if (mcyc >= free_cyc) begin
                if (bus.read_req || m_pending) begin
                    model_pick(bus.occ, bus.head_data, resp_pop, resp_readd, resp_empty);
                    resp_valid = 1'b1;
                    resp_cyc   = mcyc + 3;
                    free_cyc   = mcyc + 4;
                    m_pending  = 1'b0;
                end
            end else if (bus.read_req) begin
                if (m_pending) m_ovr = (m_ovr + 1) % 1024;
                else           m_pending = 1'b1;
            end
            mcyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request with fixed queue state; literal check of the k+3 strobe cycle.
    task automatic read_check(input string name, input logic [11:0] o, input logic [7:0] h,
                              input logic [3:0] ep, input logic [3:0] er, input logic ee);
        bus.occ = o;
        bus.head_data = h;
        tick();
        bus.read_req = 1'b1;              // cycle k
        tick();
        bus.read_req = 1'b0;              // k+1
        tick();                           // k+2
        tick();                           // k+3
        @(negedge clk);
        chk({name, "_pop"},   32'(bus.pop),        32'(ep));
        chk({name, "_valid"}, 32'(bus.read_valid), 32'd1);
        chk({name, "_readd"}, 32'(bus.readd),      32'(er));
        chk({name, "_empty"}, 32'(bus.read_empty), 32'(ee));
        tick();                           // k+4
        $display("read %s: occ=%03h head=%02h pop=%b readd=%b empty=%b",
                 name, o, h, bus.pop, bus.readd, bus.read_empty);
    endtask

    initial begin
        reset = 1'b1;
        bus.read_req = 1'b0;
        bus.occ = '0;
        bus.head_data = '0;

        // Requests during reset are ignored.
        tick(); bus.read_req = 1'b1;
        tick(); bus.read_req = 1'b0;
        tick(); bus.read_req = 1'b1;
        tick(); bus.read_req = 1'b0;
        @(negedge clk);
        chk("rst_pop",   32'(bus.pop),         32'd0);
        chk("rst_readd", 32'(bus.readd),       32'd0);
        chk("rst_valid", 32'(bus.read_valid),  32'd0);
        chk("rst_rx",    32'(bus.ct_received), 32'd0);
        chk("rst_ovr",   32'(bus.ct_overrun),  32'd0);
        $display("reset: pop=%b readd=%b valid=%b", bus.pop, bus.readd, bus.read_valid);
        tick();
        reset = 1'b0;

        // All empty with back-to-back requests at k, k+1, k+2.
        bus.occ = '0;
        tick();
        bus.read_req = 1'b1;              // k
        tick();                           // k+1
        tick();                           // k+2
        tick();
        bus.read_req = 1'b0;              // k+3
        @(negedge clk);
        chk("empty1_valid", 32'(bus.read_valid), 32'd1);
        chk("empty1_empty", 32'(bus.read_empty), 32'd1);
        chk("empty1_pop",   32'(bus.pop),        32'd0);
        chk("empty1_readd", 32'(bus.readd),      32'd0);
        tick(); tick(); tick(); tick();   // k+7
        @(negedge clk);
        chk("empty2_valid", 32'(bus.read_valid), 32'd1);
        chk("empty2_empty", 32'(bus.read_empty), 32'd1);
        tick();                           // k+8
        @(negedge clk);
        chk("empty_ovr", 32'(bus.ct_overrun),  32'd1);
        chk("empty_rx",  32'(bus.ct_received), 32'd0);
        $display("empty: ct_overrun=%0d ct_received=%0d", bus.ct_overrun, bus.ct_received);
        tick();

        read_check("single", pk(1, 0, 0, 0), 8'b00_00_00_10, 4'b0001, 4'b0010, 1'b0);
        @(negedge clk);
        chk("single_rx", 32'(bus.ct_received), 32'd1);
        tick();

        read_check("llq",   pk(2, 0, 0, 5), 8'b01_00_00_00, 4'b1000, 4'b1101, 1'b0);
        read_check("wfq",   pk(2, 0, 0, 2), 8'b01_00_00_11, 4'b0001, 4'b0011, 1'b0);
        read_check("ovr_q0", pk(6, 3, 5, 0), 8'b00_10_01_01, 4'b0001, 4'b0001, 1'b0);
        read_check("ovr_q2", pk(6, 5, 5, 0), 8'b00_10_01_01, 4'b0100, 4'b1010, 1'b0);
        read_check("clamp", pk(0, 0, 6, 7), 8'b11_00_00_00, 4'b1000, 4'b1111, 1'b0);
        read_check("q1win", pk(0, 6, 5, 0), 8'b00_00_01_00, 4'b0010, 4'b0101, 1'b0);
        @(negedge clk);
        chk("rx_total", 32'(bus.ct_received), 32'd7);
        tick();

        // Reset one cycle after a request aborts it.
        bus.occ = pk(1, 0, 0, 0);
        bus.head_data = 8'b00_00_00_10;
        tick();
        bus.read_req = 1'b1;              // k
        tick();
        bus.read_req = 1'b0;
        reset = 1'b1;                     // k+1
        tick();
        reset = 1'b0;                     // k+2
        tick();                           // k+3
        @(negedge clk);
        chk("abort_pop",   32'(bus.pop),         32'd0);
        chk("abort_valid", 32'(bus.read_valid),  32'd0);
        chk("abort_rx",    32'(bus.ct_received), 32'd0);
        $display("abort: pop=%b valid=%b", bus.pop, bus.read_valid);
        tick();
        read_check("after_rst", pk(1, 0, 0, 0), 8'b00_00_00_10, 4'b0001, 4'b0010, 1'b0);

        tick(); tick();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qos_read_scheduler.md
Name: qos_read_scheduler

Overview:
- Dequeue scheduler for the four-queue QoS buffer (queues Q0..Q3, each holding up to 6 two-bit entries).
- On each read request it snapshots the queue occupancies and maps each one through a fixed weight table. The weight table gives LLQ-like behaviour at low occupancy and WFQ-like behaviour at high occupancy.
- It picks the highest-weight queue, issues a one-hot pop to that queue, and presents the 4-bit output word {queue_id, data}.
- It sits between the queue storage block and the display/readout logic, and owns the received-packet statistics.

Parameters:
OCC_W, 3, occupancy count width per queue (legal values 0..6)
CNT_W, 10, width of statistics counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
read_req  in  1  one-cycle read request pulse (debounced upstream)
occ  in  4*OCC_W  occupancy of Qi at bits [i*OCC_W +: OCC_W]
head_data  in  8  head entry of Qi at bits [2i+1:2i]
pop  out  4  one-hot dequeue strobe to queue storage
readd  out  4  {queue_id[1:0], data[1:0]} of last serviced read
read_valid  out  1  one-cycle strobe, readd updated
read_empty  out  1  qualifies read_valid: all queues were empty
ct_received  out  CNT_W  count of successful dequeues
ct_overrun  out  CNT_W  count of requests lost while busy

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - The pending flag and all snapshot registers are 0.
  - Reset asserted mid-operation aborts immediately: no pop is issued and no counter changes.
- FSM states: IDLE -> EVAL -> ISSUE -> WAIT -> IDLE.
  - IDLE: if read_req or pending is set, capture occ and head_data into snapshot registers, clear pending, and go to EVAL.
  - EVAL: compute weights and the winner from the snapshot, register the winner, and go to ISSUE.
  - ISSUE: register the outputs for the next cycle and go to WAIT.
  - WAIT: pop, read_valid and read_empty are high for exactly this one cycle and clear at its end; go to IDLE. The queue updates occ at the end of this cycle, so the next snapshot sees fresh occupancy.
- Latency: for read_req high in cycle k, pop, read_valid and readd are valid in cycle k+3. The next request is accepted in cycle k+4.
- Requests while busy (state not IDLE):
  - read_req with pending clear sets pending.
  - read_req with pending already set increments ct_overrun (wrapping).
  - A pending request is serviced exactly like a fresh read_req in the next IDLE cycle.
- Weight table, indexed by occupancy 0..6 (an occupancy of 7 is treated as 6):
  - Q0: 0,9,13,15,16,17,19
  - Q1: 0,6,8,12,14,18,21
  - Q2: 0,3,5,7,11,19,23
  - Q3: 0,1,2,4,10,22,24
- Weight override: if occ0==6 and occ2==5, then w0=20 when occ1<5; otherwise w2=20.
- Winner selection:
  - The winner is the queue with the strictly greatest weight.
  - Ties go to the higher queue index (Q3 > Q2 > Q1 > Q0).
  - A queue with weight 0 is never selected.
- Successful read:
  - pop[winner]=1.
  - readd = {winner[1:0], head_data of winner}.
  - read_empty=0.
  - ct_received increments (wrapping at 2^CNT_W).
- All queues empty:
  - pop=0, readd=4'b0000, read_valid=1, read_empty=1.
  - ct_received is unchanged.
- readd holds its value between reads.
- All weight arithmetic is unsigned, 6 bits.

Decomposition:
- Package qos_pkg contains:
  - the queue-id typedef (2 bits);
  - the weight typedef (6 bits);
  - NUM_Q=4 and QDEPTH=6;
  - the four weight-table constant arrays;
  - the override constant (20).
- Sub-module qos_weight_arbiter is purely combinational. Inputs: snapshot occupancies. Outputs: winner id and any_nonempty. The FSM registers its output during EVAL.

Test Plan:
- Reset: drive read_req pulses while reset=1 -> pop=0, readd=0, read_valid=0, both counters 0.
- Single queue: occ={Q0=1, others 0}, head Q0=2'b10, read_req at k -> cycle k+3 shows pop=4'b0001, readd=4'b0010, read_valid=1, read_empty=0; ct_received=1 from k+4.
- LLQ vs WFQ: occ Q0=2 (w13), Q3=5 (w22), head Q3=2'b01 -> pop=4'b1000, readd=4'b1101. Then with Q0=2, Q3=2 (w13 vs w2) -> pop=4'b0001.
- Override: occ Q0=6, Q1=3, Q2=5, Q3=0 -> w0=20 beats w2=19, pop=4'b0001. With Q1 changed to 5 -> w2=20 beats w0=19 and w1=18, pop=4'b0100.
- Empty plus overrun: all occ=0, read_req at k, k+1, k+2 -> empty strobe at k+3 (read_empty=1, readd=0, pop=0), second empty strobe at k+7, ct_overrun=1, ct_received=0.
- Reset mid-operation: read_req at k, reset in cycle k+1 -> no pop/read_valid at k+3, state IDLE; a fresh read_req after reset is serviced with the normal 3-cycle latency.
